// File: rtl/hdmi_init_sequencer.sv
// Power-up / hot-plug sequencer for the I2C configuration controller: lock and hot-plug gating,
// controller reset and start, timeout with bounded retries, video enable. Define HDMI_SEQ_HPD_EN for hot-plug gating.
module hdmi_init_sequencer #(
  parameter int PWR_DELAY    = 1000,
  parameter int TIMEOUT      = 2000000,
  parameter int MAX_RETRY    = 3,
  parameter int HPD_DEBOUNCE = 1000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           pll_locked_i,
  input  logic                           hpd_i,
  input  logic                           cfg_done_i,
  output logic                           cfg_rst_n_o,
  output logic                           cfg_start_o,
  output logic                           video_en_o,
  output logic                           error_o,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

  localparam int MAX_AB     = (PWR_DELAY > TIMEOUT) ? PWR_DELAY : TIMEOUT;
  localparam int MAX_CNT    = (MAX_AB > HPD_DEBOUNCE) ? MAX_AB : HPD_DEBOUNCE;
  localparam int CW         = $clog2(MAX_CNT) + 1;
  localparam int RW         = $clog2(MAX_RETRY + 1);
  localparam int RST_CYCLES = 4;

  typedef enum logic [3:0] {
    S_WAIT_LOCK = 4'd0,
    S_WAIT_HPD  = 4'd1,
    S_DEBOUNCE  = 4'd2,
    S_RST_CFG   = 4'd3,
    S_PWR_WAIT  = 4'd4,
    S_START     = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_RUN       = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

  state_t        state_q, state_d, state_nxt;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic [RW-1:0] retry_q, retry_d, retry_nxt;
  logic          lock_lost;
  logic          cfg_rst_n_q, cfg_rst_n_d;
  logic          cfg_start_q, cfg_start_d;
  logic          video_en_q, video_en_d;
  logic          error_q, error_d;
  logic [1:0]    lock_sync_q, lock_sync_d;
  logic          lock_s;

  assign lock_s = lock_sync_q[1];

  // Next value of the lock synchronizer chain.
  always_comb begin
    lock_sync_d = {lock_sync_q[0], pll_locked_i};
  end

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= lock_sync_d;
    end
  end

`ifdef HDMI_SEQ_HPD_EN
  logic [1:0] hpd_sync_q, hpd_sync_d;
  logic       hpd_s;

  assign hpd_s = hpd_sync_q[1];

  // Next value of the hot-plug synchronizer chain.
  always_comb begin
    hpd_sync_d = {hpd_sync_q[0], hpd_i};
  end

  // Two-flop synchronizer for the asynchronous hot-plug detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hpd_sync_q <= 2'b00;
    end else begin
      hpd_sync_q <= hpd_sync_d;
    end
  end
`else
  logic unused_hpd_s;
  assign unused_hpd_s = hpd_i;
`endif

  // Counter value loaded on entry so a state of N cycles exits when the counter reaches zero.
  function automatic logic [CW-1:0] entry_load(input state_t s);
    case (s)
      S_DEBOUNCE:  entry_load = CW'(HPD_DEBOUNCE - 1);
      S_RST_CFG:   entry_load = CW'(RST_CYCLES - 1);
      S_PWR_WAIT:  entry_load = CW'(PWR_DELAY - 1);
      S_WAIT_DONE: entry_load = CW'(TIMEOUT - 1);
      default:     entry_load = {CW{1'b0}};
    endcase
  endfunction

  // Sequencer next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_q;
    cnt_dec   = (cnt_q != {CW{1'b0}}) ? (cnt_q - CW'(1)) : cnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s) begin
`ifdef HDMI_SEQ_HPD_EN
          state_nxt = S_WAIT_HPD;
`else
          state_nxt = S_RST_CFG;
          retry_nxt = {RW{1'b0}};
`endif
        end else begin
          state_nxt = S_WAIT_LOCK;
        end
      end
      S_WAIT_HPD: begin
`ifdef HDMI_SEQ_HPD_EN
        if (hpd_s) begin
          state_nxt = S_DEBOUNCE;
        end else begin
          state_nxt = S_WAIT_HPD;
        end
`else
        state_nxt = S_WAIT_LOCK;
`endif
      end
      S_DEBOUNCE: begin
`ifdef HDMI_SEQ_HPD_EN
        if (!hpd_s) begin
          state_nxt = S_WAIT_HPD;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_nxt = S_RST_CFG;
        end else begin
          state_nxt = S_DEBOUNCE;
        end
`else
        state_nxt = S_WAIT_LOCK;
`endif
      end
      S_RST_CFG: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_nxt = S_PWR_WAIT;
        end else begin
          state_nxt = S_RST_CFG;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_nxt = S_START;
        end else begin
          state_nxt = S_PWR_WAIT;
        end
      end
      S_START: begin
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (cfg_done_i) begin
          state_nxt = S_RUN;
        end else if (cnt_q == {CW{1'b0}}) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_nxt = retry_q + RW'(1);
            state_nxt = S_RST_CFG;
          end else begin
            state_nxt = S_FAIL;
          end
        end else begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_RUN, S_FAIL: begin
`ifdef HDMI_SEQ_HPD_EN
        if (!hpd_s) begin
          state_nxt = S_WAIT_HPD;
        end else begin
          state_nxt = state_q;
        end
`else
        state_nxt = state_q;
`endif
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
      end
    endcase

    // Lock loss overrides everything, including a same-cycle retry increment.
    lock_lost = (state_q != S_WAIT_LOCK) && !lock_s;
    state_d   = lock_lost ? S_WAIT_LOCK : state_nxt;
    retry_d   = lock_lost ? retry_q : retry_nxt;
    if ((state_d == S_WAIT_HPD) && (state_q != S_WAIT_HPD)) begin
      retry_d = {RW{1'b0}};
    end else begin
      retry_d = retry_d;
    end
    cnt_d = (state_d != state_q) ? entry_load(state_d) : cnt_dec;
  end

  // Output decode of the next state so outputs come straight from flops.
  always_comb begin
    cfg_rst_n_d = (state_d == S_PWR_WAIT) || (state_d == S_START) ||
                  (state_d == S_WAIT_DONE) || (state_d == S_RUN);
    cfg_start_d = (state_d == S_START);
    video_en_d  = (state_d == S_RUN);
    error_d     = (state_d == S_FAIL);
  end

  // Sequencer state, counter, retry count and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= {CW{1'b0}};
      retry_q     <= {RW{1'b0}};
      cfg_rst_n_q <= 1'b0;
      cfg_start_q <= 1'b0;
      video_en_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      cfg_rst_n_q <= cfg_rst_n_d;
      cfg_start_q <= cfg_start_d;
      video_en_q  <= video_en_d;
      error_q     <= error_d;
    end
  end

  assign cfg_rst_n_o = cfg_rst_n_q;
  assign cfg_start_o = cfg_start_q;
  assign video_en_o  = video_en_q;
  assign error_o     = error_q;
  assign retry_cnt_o = retry_q;

endmodule
